// File: rtl/spi_master_pkg.sv
// Shared types and constants for the SPI master.
package spi_master_pkg;

    localparam int unsigned MAX_BITS = 32;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned NB_W     = 8;

    // Transaction handshake states.
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ACK
    } state_t;

    // Segments of one lane sequencer: lead delay, active part, idle part, finished.
    typedef enum logic [1:0] {
        SEG_LEAD,
        SEG_ON,
        SEG_OFF,
        SEG_DONE
    } seg_t;

    // Per-lane timing captured at acceptance.
    typedef struct packed {
        logic [WORD_W-1:0] lead;     // cycles before the first active part
        logic [WORD_W-1:0] on_len;   // active cycles per pulse (>= 1)
        logic [WORD_W-1:0] off_len;  // idle cycles per pulse (may be 0)
        logic [WORD_W-1:0] count;    // pulses; 0 means lane complete at t=0
        logic              tail;     // keep the idle part after the last pulse
    } phase_cfg_t;

    // Zero-length intervals behave as one cycle.
    function automatic logic [WORD_W-1:0] at_least_one(input logic [WORD_W-1:0] v);
        return (v == '0) ? WORD_W'(1) : v;
    endfunction

    // Bit counts beyond the word width are limited to the word width.
    function automatic logic [WORD_W-1:0] clamp_bits(input logic [NB_W-1:0] nb);
        return (WORD_W'(nb) > MAX_BITS) ? WORD_W'(MAX_BITS) : WORD_W'(nb);
    endfunction

endpackage

// File: rtl/spi_master_phase.sv
// Generic lead/period/count sequencer used for the sclk, mosi and miso lanes.
// active_c/strobe_c describe the NEXT cycle so the caller can register its output.
module spi_master_phase
    import spi_master_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  phase_cfg_t cfg,
    output logic       strobe_c,
    output logic       active_c,
    output logic       done
);

    seg_t              seg_q, seg_d;
    logic [WORD_W-1:0] cnt_q, cnt_d;
    logic [WORD_W-1:0] bits_q, bits_d;
    phase_cfg_t        cfg_q, cfg_d;

    // Segment/counter registers; cnt counts cycles left in the current segment.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q  <= SEG_DONE;
            cnt_q  <= '0;
            bits_q <= '0;
            cfg_q  <= '0;
            done   <= 1'b1;
        end else begin
            seg_q  <= seg_d;
            cnt_q  <= cnt_d;
            bits_q <= bits_d;
            cfg_q  <= cfg_d;
            done   <= (seg_d == SEG_DONE);
        end
    end

    // Next segment, counters and look-ahead strobes.
    always_comb begin
        seg_d  = seg_q;
        cnt_d  = cnt_q;
        bits_d = bits_q;
        cfg_d  = cfg_q;
        if (load) begin
            cfg_d = cfg;
            if (cfg.count == '0) begin
                seg_d  = SEG_DONE;
                cnt_d  = '0;
                bits_d = '0;
            end else if (cfg.lead == '0) begin
                seg_d  = SEG_ON;
                cnt_d  = cfg.on_len;
                bits_d = cfg.count;
            end else begin
                seg_d  = SEG_LEAD;
                cnt_d  = cfg.lead;
                bits_d = cfg.count;
            end
        end else begin
            case (seg_q)
                SEG_LEAD: begin
                    if (cnt_q == WORD_W'(1)) begin
                        seg_d = SEG_ON;
                        cnt_d = cfg_q.on_len;
                    end else begin
                        cnt_d = cnt_q - WORD_W'(1);
                    end
                end
                SEG_ON: begin
                    if (cnt_q != WORD_W'(1)) begin
                        cnt_d = cnt_q - WORD_W'(1);
                    end else if ((cfg_q.off_len != '0) && ((bits_q != WORD_W'(1)) || cfg_q.tail)) begin
                        seg_d = SEG_OFF;
                        cnt_d = cfg_q.off_len;
                    end else if (bits_q != WORD_W'(1)) begin
                        seg_d  = SEG_ON;
                        cnt_d  = cfg_q.on_len;
                        bits_d = bits_q - WORD_W'(1);
                    end else begin
                        seg_d  = SEG_DONE;
                        cnt_d  = '0;
                        bits_d = '0;
                    end
                end
                SEG_OFF: begin
                    if (cnt_q != WORD_W'(1)) begin
                        cnt_d = cnt_q - WORD_W'(1);
                    end else if (bits_q != WORD_W'(1)) begin
                        seg_d  = SEG_ON;
                        cnt_d  = cfg_q.on_len;
                        bits_d = bits_q - WORD_W'(1);
                    end else begin
                        seg_d  = SEG_DONE;
                        cnt_d  = '0;
                        bits_d = '0;
                    end
                end
                default: begin
                    seg_d = SEG_DONE;
                end
            endcase
        end
        active_c = (seg_d == SEG_ON);
        strobe_c = (seg_d == SEG_ON) && (load || (seg_q != SEG_ON) || (cnt_q == WORD_W'(1)));
    end

endmodule

// File: rtl/spi_master.sv
// Programmable-timing SPI master with four-phase request/ack handshake.
// Build option: SPI_MASTER_LOOPBACK_EN feeds mosi back as the serial input.
module spi_master
    import spi_master_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic              rd_req,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [NB_W-1:0]   nb_mosi,
    input  logic [NB_W-1:0]   nb_miso,
    input  logic              y0_mosi,
    input  logic [WORD_W-1:0] n0_mosi,
    input  logic [WORD_W-1:0] n1_mosi,
    input  logic [WORD_W-1:0] n0_miso,
    input  logic [WORD_W-1:0] n1_miso,
    input  logic [WORD_W-1:0] nb_sclk,
    input  logic              y0_sclk,
    input  logic [WORD_W-1:0] n0_sclk,
    input  logic [WORD_W-1:0] n1_sclk,
    input  logic [WORD_W-1:0] n2_sclk,
    input  logic              miso,
    output logic              mosi,
    output logic              sclk,
    output logic [WORD_W-1:0] rd_data,
    output logic              ack
);

    state_t            state_q, state_d;
    logic              load;
    logic              y0s_l, y0m_l;
    logic              sample_q;
    logic [WORD_W-1:0] tx_sh_q, tx_sh_d;
    logic [WORD_W-1:0] nb_mosi_eff, nb_miso_eff;
    logic              sclk_d, mosi_d, ack_d;
    logic [WORD_W-1:0] rd_data_d;
    logic [WORD_W-1:0] sh_src;
    logic              y0s_eff, y0m_eff;
    logic              serial_in;

    phase_cfg_t        sclk_cfg, mosi_cfg, miso_cfg;
    logic              sclk_act_c, sclk_done, unused_sclk_strobe;
    logic              mosi_act_c, mosi_strobe_c, mosi_done;
    logic              miso_strobe_c, miso_done, unused_miso_act;

`ifdef SPI_MASTER_LOOPBACK_EN
    logic unused_miso;
    assign serial_in   = mosi;
    assign unused_miso = miso;
`else
    assign serial_in   = miso;
`endif

    assign nb_mosi_eff = clamp_bits(nb_mosi);
    assign nb_miso_eff = clamp_bits(nb_miso);

    // Lane timing from the live inputs; each sequencer captures it on load.
    always_comb begin
        sclk_cfg.lead    = n0_sclk;
        sclk_cfg.on_len  = at_least_one(n1_sclk);
        sclk_cfg.off_len = at_least_one(n2_sclk);
        sclk_cfg.count   = nb_sclk;
        sclk_cfg.tail    = 1'b1;

        mosi_cfg.lead    = n0_mosi;
        mosi_cfg.on_len  = at_least_one(n1_mosi);
        mosi_cfg.off_len = '0;
        mosi_cfg.count   = wr_req ? nb_mosi_eff : '0;
        mosi_cfg.tail    = 1'b0;

        miso_cfg.lead    = n0_mosi + n0_miso;
        miso_cfg.on_len  = WORD_W'(1);
        miso_cfg.off_len = at_least_one(n1_miso) - WORD_W'(1);
        miso_cfg.count   = rd_req ? nb_miso_eff : '0;
        miso_cfg.tail    = 1'b0;
    end

    spi_master_phase u_sclk_phase (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .cfg      (sclk_cfg),
        .strobe_c (unused_sclk_strobe),
        .active_c (sclk_act_c),
        .done     (sclk_done)
    );

    spi_master_phase u_mosi_phase (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .cfg      (mosi_cfg),
        .strobe_c (mosi_strobe_c),
        .active_c (mosi_act_c),
        .done     (mosi_done)
    );

    spi_master_phase u_miso_phase (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .cfg      (miso_cfg),
        .strobe_c (miso_strobe_c),
        .active_c (unused_miso_act),
        .done     (miso_done)
    );

    // Handshake FSM: accept, run until all lanes finish, hold ack until requests drop.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_req || rd_req) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (sclk_done && mosi_done && miso_done) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!wr_req && !rd_req) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Next values of the registered serial outputs, shift register and receive word.
    always_comb begin
        y0s_eff   = load ? y0_sclk : y0s_l;
        y0m_eff   = load ? y0_mosi : y0m_l;
        sh_src    = load ? (wr_data << (MAX_BITS - nb_mosi_eff)) : tx_sh_q;
        tx_sh_d   = sh_src;
        ack_d     = (state_d == ACK);
        sclk_d    = (state_d == RUN) ? (y0s_eff ^ sclk_act_c) : y0_sclk;

        if (state_d != RUN) begin
            mosi_d = y0_mosi;
        end else if (!mosi_act_c) begin
            mosi_d = y0m_eff;
        end else if (mosi_strobe_c) begin
            mosi_d  = sh_src[MAX_BITS-1];
            tx_sh_d = sh_src << 1;
        end else begin
            mosi_d = mosi;
        end

        rd_data_d = rd_data;
        if (load && rd_req) begin
            rd_data_d = '0;
        end else if ((state_q == RUN) && sample_q) begin
            rd_data_d = {rd_data[WORD_W-2:0], serial_in};
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ack      <= 1'b0;
            sclk     <= y0_sclk;
            mosi     <= y0_mosi;
            rd_data  <= '0;
            tx_sh_q  <= '0;
            y0s_l    <= 1'b0;
            y0m_l    <= 1'b0;
            sample_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ack      <= ack_d;
            sclk     <= sclk_d;
            mosi     <= mosi_d;
            rd_data  <= rd_data_d;
            tx_sh_q  <= tx_sh_d;
            sample_q <= miso_strobe_c;
            if (load) begin
                y0s_l <= y0_sclk;
                y0m_l <= y0_mosi;
            end
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master; miso is wired to mosi so both builds loop back.
module tb_spi_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_req, rd_req;
    logic [31:0] wr_data;
    logic [7:0]  nb_mosi, nb_miso;
    logic        y0_mosi;
    logic [31:0] n0_mosi, n1_mosi, n0_miso, n1_miso;
    logic [31:0] nb_sclk;
    logic        y0_sclk;
    logic [31:0] n0_sclk, n1_sclk, n2_sclk;
    logic        miso;
    logic        mosi, sclk;
    logic [31:0] rd_data;
    logic        ack;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign miso = mosi;

    spi_master dut (
        .clk     (clk),
        .rst     (rst),
        .wr_req  (wr_req),
        .rd_req  (rd_req),
        .wr_data (wr_data),
        .nb_mosi (nb_mosi),
        .nb_miso (nb_miso),
        .y0_mosi (y0_mosi),
        .n0_mosi (n0_mosi),
        .n1_mosi (n1_mosi),
        .n0_miso (n0_miso),
        .n1_miso (n1_miso),
        .nb_sclk (nb_sclk),
        .y0_sclk (y0_sclk),
        .n0_sclk (n0_sclk),
        .n1_sclk (n1_sclk),
        .n2_sclk (n2_sclk),
        .miso    (miso),
        .mosi    (mosi),
        .sclk    (sclk),
        .rd_data (rd_data),
        .ack     (ack)
    );

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] nbs;
        logic [7:0]  nbm;
        logic [7:0]  nbi;
        logic [31:0] data;
        logic [31:0] exp_rd;
        int          exp_ack_t;
        int          exp_pulses;
        int          exp_fall;
        logic        exp_mosi_idle;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_base();
        n0_sclk = 32'd10; n1_sclk = 32'd5; n2_sclk = 32'd5; y0_sclk = 1'b1;
        n0_mosi = 32'd10; n1_mosi = 32'd10; y0_mosi = 1'b1;
        n0_miso = 32'd5;  n1_miso = 32'd10;
    endtask

    // Start a transaction and watch it cycle by cycle (t=0 is the first cycle after acceptance).
    task automatic run_txn(input vec_t v, output int ack_t, output int pulses,
                           output int first_fall, output int bad_fall, output int bad_mosi);
        logic prev_s, prev_m;
        @(negedge clk);
        set_base();
        nb_sclk = v.nbs; nb_mosi = v.nbm; nb_miso = v.nbi; wr_data = v.data;
        wr_req = v.wr; rd_req = v.rd;
        prev_s = 1'b1; prev_m = 1'b1;
        ack_t = -1; pulses = 0; first_fall = -1; bad_fall = 0; bad_mosi = 0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (sclk === 1'b0 && prev_s === 1'b1) begin
                pulses++;
                if (first_fall < 0) first_fall = t;
                if ((t % 10) != 0) bad_fall++;
            end
            if (mosi !== prev_m) begin
                if (v.exp_mosi_idle || (t % 10) != 0) bad_mosi++;
            end
            prev_s = sclk;
            prev_m = mosi;
            if (t == 0) begin
                // Configuration changes after acceptance must not matter.
                n0_sclk = 32'd3; n1_sclk = 32'd0; n2_sclk = 32'd7; nb_sclk = 32'd5;
                n0_mosi = 32'd1; n1_mosi = 32'd3; n0_miso = 32'd2; n1_miso = 32'd0;
                nb_mosi = 8'd3; nb_miso = 8'd4; wr_data = 32'h0;
            end
            if (ack === 1'b1) begin
                ack_t = t;
                break;
            end
        end
    endtask

    initial begin
        int ack_t, pulses, ff, bf, bm, viol;

        rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
        set_base();
        wr_data = '0; nb_mosi = 8'd16; nb_miso = 8'd16; nb_sclk = 32'd16;
        repeat (3) @(negedge clk);
        check("reset_ack",  32'(ack),  32'd0);
        check("reset_rd",   rd_data,   32'd0);
        check("reset_sclk", 32'(sclk), 32'd1);
        check("reset_mosi", 32'(mosi), 32'd1);
        rst = 1'b0;

        //           wr    rd    nbs     nbm    nbi    data           exp_rd         ack  pul fall idle
        vecs[0] = '{1'b1, 1'b1, 32'd16, 8'd16, 8'd16, 32'h0000_5aaa, 32'h0000_5aaa, 171, 16, 10, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'd17, 8'd17, 8'd17, 32'h0001_5aaa, 32'h0001_5aaa, 181, 17, 10, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 32'd16, 8'd16, 8'd16, 32'h1234_5678, 32'h0000_ffff, 171, 16, 10, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 32'd0,  8'd0,  8'd0,  32'hffff_ffff, 32'h0000_ffff, 1,   0,  -1, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 32'd8,  8'd8,  8'd8,  32'h0000_00a5, 32'h0000_ffff, 91,  8,  10, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 32'd32, 8'd40, 8'd40, 32'hdead_beef, 32'hdead_beef, 331, 32, 10, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 32'd16, 8'd16, 8'd8,  32'h0000_5aaa, 32'h0000_005a, 171, 16, 10, 1'b0};

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i], ack_t, pulses, ff, bf, bm);
            check($sformatf("v%0d_ack_t", i),      32'(ack_t),  32'(vecs[i].exp_ack_t));
            check($sformatf("v%0d_rd_data", i),    rd_data,     vecs[i].exp_rd);
            check($sformatf("v%0d_pulses", i),     32'(pulses), 32'(vecs[i].exp_pulses));
            check($sformatf("v%0d_first_fall", i), 32'(ff),     32'(vecs[i].exp_fall));
            check($sformatf("v%0d_fall_grid", i),  32'(bf),     32'd0);
            check($sformatf("v%0d_mosi_grid", i),  32'(bm),     32'd0);
            if (i == 0) begin
                // Requests held after ack: ack stays, no new sclk activity.
                viol = 0;
                for (int c = 0; c < 50; c++) begin
                    @(negedge clk);
                    if (ack !== 1'b1 || sclk !== 1'b1 || mosi !== 1'b1) viol++;
                end
                check("hold_ack_quiet", 32'(viol), 32'd0);
            end
            wr_req = 1'b0; rd_req = 1'b0;
            @(negedge clk);
            check($sformatf("v%0d_ack_drop", i), 32'(ack), 32'd0);
        end

        // Reset in the middle of a transaction aborts it without ack.
        @(negedge clk);
        set_base();
        nb_sclk = 32'd16; nb_mosi = 8'd16; nb_miso = 8'd16; wr_data = 32'h0000_5aaa;
        wr_req = 1'b1; rd_req = 1'b1;
        for (int t = 0; t <= 50; t++) @(negedge clk);
        check("abort_pre_sclk", 32'(sclk), 32'd0);
        check("abort_pre_rd",   rd_data,   32'h0000_0005);
        rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
        @(negedge clk);
        check("abort_sclk", 32'(sclk), 32'd1);
        check("abort_mosi", 32'(mosi), 32'd1);
        check("abort_ack",  32'(ack),  32'd0);
        check("abort_rd",   rd_data,   32'd0);
        rst = 1'b0;
        viol = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (ack !== 1'b0 || sclk !== 1'b1) viol++;
        end
        check("abort_no_ack", 32'(viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
